pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush/run controller for the 5-stage MIPS-DLX pipeline.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble.
- Squashes wrong-path instructions on taken branches and freezes the pipeline while data memory is busy.
- Sequences run/step/halt debug control, including draining the pipe on a HALT instruction.
- Sits beside the forwarding unit and drives the PC and pipeline-register enables/flushes.

## Interface
- `START_RUN`, default 1: state after reset (1 = RUN, 0 = HALT).
- `DRAIN_CYCLES`, default 3: advancing cycles for a HALT in ID to reach WB and retire.
- `clk` input 1: single clock; everything samples on the rising edge.
- `reset` input 1: synchronous, active-low.
- `rs_ID`, `rt_ID` input 5 each: source registers of the instruction in ID.
- `uses_rt_ID` input 1: the ID instruction reads `rt` (not an I-type destination).
- `rt_EX` input 5: destination of the instruction in EX.
- `mem_read_EX_ctrl` input 1: the EX instruction is a load.
- `branch_taken_EX` input 1: the branch in EX resolved taken.
- `halt_ID` input 1: the ID instruction is HALT.
- `mem_busy` input 1: data memory wait request.
- `dbg_run`, `dbg_step`, `dbg_halt` input 1 each: single-cycle debug command pulses.
- `pc_en`, `if_id_en`, `pipe_en` output 1 each: register enables. `pipe_en` covers ID/EX, EX/MEM and MEM/WB.
- `if_id_flush`, `id_ex_flush` output 1 each: load NOP into the register at the next edge. Flush overrides enable.
- `halted` output 1, registered: the pipeline is stopped in HALT.
- `stall_count` output 16, registered: load-use bubbles inserted, saturating at 0xFFFF.

## Operation
- FSM states: RUN, HALT, STEP, DRAIN. Drain counter is 2 bits wide.
- `adv` is 1 when state ∈ {RUN, STEP, DRAIN} and `mem_busy` = 0.
- Load-use: `lu` = `mem_read_EX_ctrl` && `rt_EX` != 0 && (`rt_EX` == `rs_ID` || (`uses_rt_ID` && `rt_EX` == `rt_ID`)).
- Output priority, highest first:
  1. `!adv`: all enables 0, all flushes 0 (freeze).
  2. `branch_taken_EX`: `pc_en`, `if_id_en` and `pipe_en` = 1; `if_id_flush` = `id_ex_flush` = 1. `lu` and `halt_ID` are ignored because ID is squashed.
  3. `lu`: `pc_en` = `if_id_en` = 0, `pipe_en` = 1, `id_ex_flush` = 1. `stall_count` increments.
  4. Otherwise: all enables 1, flushes 0.
- In DRAIN, `pc_en` is forced 0 and `if_id_flush` forced 1, so only bubbles enter.
- Transitions, evaluated every cycle; debug priority is `dbg_halt` > `dbg_step` > `dbg_run`:
  - RUN → HALT on `dbg_halt`.
  - RUN → DRAIN when `adv` && `halt_ID` && !`branch_taken_EX` && !`lu`. Drain counter loads `DRAIN_CYCLES`. The HALT advances to ID/EX on that edge.
  - DRAIN: counter decrements on each `adv` cycle; → HALT when counter = 1 and `adv`. `dbg_halt` → HALT immediately. `dbg_run` and `dbg_step` are ignored.
  - HALT → STEP on `dbg_step`; HALT → RUN on `dbg_run`.
  - STEP → HALT after one `adv` cycle. While `mem_busy`, STEP holds. A HALT qualified during the step cycle → DRAIN.
- `halted` = 1 exactly when state = HALT (registered).
- `stall_count` counts only cycles where `adv` && !`branch_taken_EX` && `lu`.

## Timing
- All enable and flush outputs are combinational from state and inputs, with zero latency to the pipeline register edge.
- Reset (`reset` = 0 sampled at an edge), from the following cycle:
  - state = RUN if `START_RUN`, else HALT; `halted` = !`START_RUN`.
  - `stall_count` = 0; drain counter = 0.
- While `reset` = 0, outputs are forced to `pc_en` = `if_id_en` = `pipe_en` = 0 and `if_id_flush` = `id_ex_flush` = 1, so the pipe fills with NOPs.
- Reset mid-DRAIN or mid-STEP abandons the operation with no residual count.
- A load-use stall lasts exactly one cycle. If `mem_busy` arrives during it, the stall extends with no extra bubble and no extra count.
- A debug command is acted on at the edge where it is sampled. Commands arriving in a state that does not accept them are dropped, not queued.
- A taken branch in the cycle HALT is in ID squashes the HALT; no DRAIN occurs.

## Test plan
- Load-use: `lw r5` in EX (`mem_read_EX_ctrl` = 1, `rt_EX` = 5), `rs_ID` = 5 → one cycle of `pc_en` = 0, `if_id_en` = 0, `id_ex_flush` = 1; `stall_count` goes 0 → 1; next cycle all enables 1. Repeat with `rt_EX` = 0 → no stall.
- Branch + hazard together: `branch_taken_EX` = 1 with `lu` = 1 → both flushes 1, `pc_en` = 1, `stall_count` unchanged.
- Memory freeze: `mem_busy` held 3 cycles during a `lu` cycle → all outputs 0 for 3 cycles, then a single bubble, `stall_count` +1 total.
- HALT drain: RUN, `halt_ID` = 1 → `pc_en` = 0 and `if_id_flush` = 1 for 3 advancing cycles; `halted` rises on the 4th edge. Insert one `mem_busy` cycle → `halted` one cycle later.
- Debug stepping: `START_RUN` = 0 after reset → `halted` = 1, enables 0. `dbg_step` pulse → exactly one cycle of enables 1, then `halted` = 1. Same-cycle `dbg_step` + `dbg_halt` → stays HALT.
- Reset mid-DRAIN: `reset` = 0 in the 2nd drain cycle → NOP-fill outputs during reset; RUN afterwards with `stall_count` = 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/run controller for the 5-stage pipeline: load-use bubbles,
// branch squash, memory freeze and run/step/halt debug sequencing with HALT drain.
//
// state | meaning
// RUN   | free running
// HALT  | pipeline stopped, all registers hold
// STEP  | one advancing cycle, then back to HALT
// DRAIN | HALT instruction retiring, only bubbles enter behind it
module pipeline_hazard_ctrl #(
  parameter bit START_RUN    = 1'b1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        uses_rt_ID,
  input  logic [4:0]  rt_EX,
  input  logic        mem_read_EX_ctrl,
  input  logic        branch_taken_EX,
  input  logic        halt_ID,
  input  logic        mem_busy,
  input  logic        dbg_run,
  input  logic        dbg_step,
  input  logic        dbg_halt,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        pipe_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halted,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    STEP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] drain_cnt;
  logic       adv;
  logic       lu;
  logic       halt_go;
  logic       stall_cnt_inc;

  assign adv = (state != HALT) && !mem_busy;
  assign lu  = mem_read_EX_ctrl && (rt_EX != 5'd0) &&
               ((rt_EX == rs_ID) || (uses_rt_ID && (rt_EX == rt_ID)));
  // A HALT only counts once it actually leaves ID this cycle.
  assign halt_go       = adv && halt_ID && !branch_taken_EX && !lu;
  assign stall_cnt_inc = adv && !branch_taken_EX && lu;

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    pipe_en     = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!reset) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (adv) begin
      if (branch_taken_EX) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        pipe_en     = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        pipe_en     = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        pipe_en  = 1'b1;
      end
      if (state == DRAIN) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= START_RUN ? RUN : HALT;
      halted      <= !START_RUN;
      drain_cnt   <= 2'd0;
      stall_count <= 16'd0;
    end else begin
      if (stall_cnt_inc && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      case (state)
        RUN: begin
          if (dbg_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (halt_go) begin
            state     <= DRAIN;
            drain_cnt <= 2'(DRAIN_CYCLES);
          end
        end
        HALT: begin
          if (dbg_halt) begin
            state <= HALT;
          end else if (dbg_step) begin
            state  <= STEP;
            halted <= 1'b0;
          end else if (dbg_run) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        STEP: begin
          if (dbg_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (halt_go) begin
            state     <= DRAIN;
            drain_cnt <= 2'(DRAIN_CYCLES);
          end else if (adv) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        DRAIN: begin
          if (dbg_halt) begin
            state     <= HALT;
            halted    <= 1'b1;
            drain_cnt <= 2'd0;
          end else if (adv) begin
            drain_cnt <= drain_cnt - 2'd1;
            if (drain_cnt == 2'd1) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        default: begin
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a run-at-reset instance and a
// halt-at-reset instance, checked through an expectation queue.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_ID, rt_ID, rt_EX;
  logic        uses_rt_ID, mem_read_EX_ctrl, branch_taken_EX, halt_ID, mem_busy;
  logic        dbg_run, dbg_step, dbg_halt;
  logic        h_run, h_step, h_halt;

  logic        pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, halted;
  logic [15:0] stall_count;
  logic        h_pc_en, h_if_id_en, h_pipe_en, h_if_id_flush, h_id_ex_flush, h_halted;
  logic [15:0] h_stall_count;

  int vectors     = 0;
  int miscompares = 0;

  // {pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush}
  localparam logic [4:0] C_RUN = 5'b11100;
  localparam logic [4:0] C_LU  = 5'b00101;
  localparam logic [4:0] C_FRZ = 5'b00000;
  localparam logic [4:0] C_BR  = 5'b11111;
  localparam logic [4:0] C_DR  = 5'b01110;
  localparam logic [4:0] C_RST = 5'b00011;

  typedef struct {
    string       tag;
    bit          which;
    logic [21:0] exp;
  } sb_t;

  sb_t q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.START_RUN(1'b1), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .rt_EX(rt_EX), .mem_read_EX_ctrl(mem_read_EX_ctrl), .branch_taken_EX(branch_taken_EX),
    .halt_ID(halt_ID), .mem_busy(mem_busy), .dbg_run(dbg_run), .dbg_step(dbg_step),
    .dbg_halt(dbg_halt), .pc_en(pc_en), .if_id_en(if_id_en), .pipe_en(pipe_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .halted(halted),
    .stall_count(stall_count)
  );

  pipeline_hazard_ctrl #(.START_RUN(1'b0), .DRAIN_CYCLES(3)) dut_h (
    .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .rt_EX(rt_EX), .mem_read_EX_ctrl(mem_read_EX_ctrl), .branch_taken_EX(branch_taken_EX),
    .halt_ID(halt_ID), .mem_busy(mem_busy), .dbg_run(h_run), .dbg_step(h_step),
    .dbg_halt(h_halt), .pc_en(h_pc_en), .if_id_en(h_if_id_en), .pipe_en(h_pipe_en),
    .if_id_flush(h_if_id_flush), .id_ex_flush(h_id_ex_flush), .halted(h_halted),
    .stall_count(h_stall_count)
  );

  function automatic logic [21:0] obs_m();
    return {pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, halted, stall_count};
  endfunction

  function automatic logic [21:0] obs_h();
    return {h_pc_en, h_if_id_en, h_pipe_en, h_if_id_flush, h_id_ex_flush, h_halted, h_stall_count};
  endfunction

  task automatic expect_m(input string tag, input logic [4:0] ctl, input logic h,
                          input logic [15:0] cnt);
    sb_t e;
    e.tag = tag; e.which = 1'b0; e.exp = {ctl, h, cnt};
    q.push_back(e);
  endtask

  task automatic expect_h(input string tag, input logic [4:0] ctl, input logic h,
                          input logic [15:0] cnt);
    sb_t e;
    e.tag = tag; e.which = 1'b1; e.exp = {ctl, h, cnt};
    q.push_back(e);
  endtask

  // Compare everything queued for this cycle at the falling edge, then step past the rising edge.
  task automatic tick();
    sb_t         e;
    logic [21:0] obs;
    @(negedge clk);
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = e.which ? obs_h() : obs_m();
      vectors++;
      assert (obs === e.exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_ID = 5'd1; rt_ID = 5'd2; uses_rt_ID = 1'b1; rt_EX = 5'd7;
    mem_read_EX_ctrl = 1'b0; branch_taken_EX = 1'b0; halt_ID = 1'b0; mem_busy = 1'b0;
    dbg_run = 1'b0; dbg_step = 1'b0; dbg_halt = 1'b0;
    h_run = 1'b0; h_step = 1'b0; h_halt = 1'b0;
  endtask

  task automatic load_use_r5();
    mem_read_EX_ctrl = 1'b1; rt_EX = 5'd5; rs_ID = 5'd5;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    tick();
    expect_m("rst_hold", C_RST, 1'b0, 16'd0);
    expect_h("rst_hold_h", C_RST, 1'b1, 16'd0);
    tick();

    reset = 1'b1;
    expect_m("run_idle", C_RUN, 1'b0, 16'd0);
    expect_h("h_idle", C_FRZ, 1'b1, 16'd0);
    tick();

    // Halt-at-reset instance: step and halt in the same cycle, then a clean step.
    h_step = 1'b1; h_halt = 1'b1;
    expect_h("h_step_halt", C_FRZ, 1'b1, 16'd0);
    tick();
    h_step = 1'b0; h_halt = 1'b0;
    expect_h("h_stay", C_FRZ, 1'b1, 16'd0);
    tick();
    h_step = 1'b1;
    expect_h("h_step_cmd", C_FRZ, 1'b1, 16'd0);
    tick();
    h_step = 1'b0;
    expect_h("h_step", C_RUN, 1'b0, 16'd0);
    tick();
    expect_h("h_step_done", C_FRZ, 1'b1, 16'd0);
    tick();

    // Load-use on rs.
    load_use_r5();
    expect_m("lu_stall", C_LU, 1'b0, 16'd0);
    tick();
    idle();
    expect_m("lu_after", C_RUN, 1'b0, 16'd1);
    tick();
    mem_read_EX_ctrl = 1'b1; rt_EX = 5'd0; rs_ID = 5'd0;
    expect_m("lu_r0", C_RUN, 1'b0, 16'd1);
    tick();
    // Load-use on rt, only when rt is actually read.
    idle();
    mem_read_EX_ctrl = 1'b1; rt_EX = 5'd6; rt_ID = 5'd6; uses_rt_ID = 1'b0;
    expect_m("lu_rt_unused", C_RUN, 1'b0, 16'd1);
    tick();
    uses_rt_ID = 1'b1;
    expect_m("lu_rt", C_LU, 1'b0, 16'd1);
    tick();
    idle();
    expect_m("lu_rt_after", C_RUN, 1'b0, 16'd2);
    tick();

    // Branch wins over load-use.
    load_use_r5(); branch_taken_EX = 1'b1;
    expect_m("br_lu", C_BR, 1'b0, 16'd2);
    tick();
    idle();
    expect_m("br_after", C_RUN, 1'b0, 16'd2);
    tick();

    // Memory freeze during a load-use stall.
    load_use_r5(); mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_m("mf_freeze", C_FRZ, 1'b0, 16'd2);
      tick();
    end
    mem_busy = 1'b0;
    expect_m("mf_bubble", C_LU, 1'b0, 16'd2);
    tick();
    idle();
    expect_m("mf_after", C_RUN, 1'b0, 16'd3);
    tick();

    // HALT drain.
    halt_ID = 1'b1;
    expect_m("hd_run", C_RUN, 1'b0, 16'd3);
    tick();
    halt_ID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_m("hd_drain", C_DR, 1'b0, 16'd3);
      tick();
    end
    expect_m("hd_halted", C_FRZ, 1'b1, 16'd3);
    tick();
    dbg_run = 1'b1;
    expect_m("run_cmd", C_FRZ, 1'b1, 16'd3);
    tick();
    dbg_run = 1'b0;
    expect_m("run_resumed", C_RUN, 1'b0, 16'd3);
    tick();

    // HALT drain with one memory wait cycle.
    halt_ID = 1'b1;
    expect_m("hdm_run", C_RUN, 1'b0, 16'd3);
    tick();
    halt_ID = 1'b0;
    expect_m("hdm_d1", C_DR, 1'b0, 16'd3);
    tick();
    mem_busy = 1'b1;
    expect_m("hdm_wait", C_FRZ, 1'b0, 16'd3);
    tick();
    mem_busy = 1'b0;
    expect_m("hdm_d2", C_DR, 1'b0, 16'd3);
    tick();
    expect_m("hdm_d3", C_DR, 1'b0, 16'd3);
    tick();
    expect_m("hdm_halted", C_FRZ, 1'b1, 16'd3);
    tick();

    // Debug stepping from HALT on the run-at-reset instance.
    dbg_step = 1'b1; dbg_halt = 1'b1;
    expect_m("sh_cmd", C_FRZ, 1'b1, 16'd3);
    tick();
    dbg_step = 1'b0; dbg_halt = 1'b0;
    expect_m("sh_stay", C_FRZ, 1'b1, 16'd3);
    tick();
    dbg_step = 1'b1;
    expect_m("step_cmd", C_FRZ, 1'b1, 16'd3);
    tick();
    dbg_step = 1'b0;
    expect_m("step_cyc", C_RUN, 1'b0, 16'd3);
    tick();
    expect_m("step_done", C_FRZ, 1'b1, 16'd3);
    tick();
    dbg_run = 1'b1;
    expect_m("run_cmd2", C_FRZ, 1'b1, 16'd3);
    tick();
    dbg_run = 1'b0;

    // Taken branch squashes a HALT in ID.
    halt_ID = 1'b1; branch_taken_EX = 1'b1;
    expect_m("br_halt", C_BR, 1'b0, 16'd3);
    tick();
    idle();
    expect_m("br_halt_after", C_RUN, 1'b0, 16'd3);
    tick();

    // Reset in the second drain cycle.
    halt_ID = 1'b1;
    expect_m("rd_run", C_RUN, 1'b0, 16'd3);
    tick();
    halt_ID = 1'b0;
    expect_m("rd_d1", C_DR, 1'b0, 16'd3);
    tick();
    reset = 1'b0;
    expect_m("rd_reset", C_RST, 1'b0, 16'd3);
    tick();
    reset = 1'b1;
    expect_m("rd_run_after", C_RUN, 1'b0, 16'd0);
    tick();
    expect_m("rd_run_after2", C_RUN, 1'b0, 16'd0);
    tick();
    expect_m("rd_run_after3", C_RUN, 1'b0, 16'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
